alu_controller_ram: RTL and testbench

ALU_CONTROLLER_RAM -- requirements
Module: alu_controller_ram

---
 rtl/alu_controller_ram.sv | 144 ++++++++++++++
 tb/tb_alu_controller_ram.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_controller_ram.sv
// Instruction decoder, combinational ALU and 1024x32 RAM with asynchronous clear.
// Optional macro ALU_MULDIV_EN adds the signed multiply (aluop 3) and unsigned divide (aluop 4).
module alu_controller_ram (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic [4:0]  mf,
    output logic [18:0] ctrl,
    output logic        exce_ret,
    output logic        mfc0,
    output logic        mtc0,
    input  logic [31:0] alu_x,
    input  logic [31:0] alu_y,
    input  logic [3:0]  alu_op,
    output logic [31:0] alu_r1,
    output logic [31:0] alu_r2,
    output logic        alu_eq,
    input  logic [9:0]  ram_addr,
    input  logic [31:0] ram_din,
    input  logic        ram_we,
    output logic [31:0] ram_dout
);

    typedef struct packed {
        logic [3:0] aluop;
        logic rf_dst, rf_we, branch, jump, mem_we, mem_to_reg, imm_op;
        logic branch_eq, branch_leq, jump_reg, jal, sys, shift_imm, lui, store_half;
    } ctrl_t;

    ctrl_t c;

    always_comb begin
        c        = '0;
        exce_ret = 1'b0;
        mfc0     = 1'b0;
        mtc0     = 1'b0;
        case (op)
            6'h00: begin
                c.rf_dst = 1'b1;
                c.rf_we  = 1'b1;
                case (funct)
                    6'h00:        begin c.aluop = 4'd0; c.shift_imm = 1'b1; end
                    6'h03:        begin c.aluop = 4'd1; c.shift_imm = 1'b1; end
                    6'h02:        begin c.aluop = 4'd2; c.shift_imm = 1'b1; end
                    6'h20, 6'h21: c.aluop = 4'd5;
                    6'h22, 6'h23: c.aluop = 4'd6;
                    6'h24:        c.aluop = 4'd7;
                    6'h25:        c.aluop = 4'd8;
                    6'h27:        c.aluop = 4'd10;
                    6'h2A:        c.aluop = 4'd11;
                    6'h2B:        c.aluop = 4'd12;
                    // jr and syscall carry no register-file write
                    6'h08:        begin c = '0; c.jump_reg = 1'b1; end
                    6'h0C:        begin c = '0; c.sys = 1'b1; end
                    default:      c = '0;
                endcase
            end
            6'h08, 6'h09: begin c.aluop = 4'd5;  c.imm_op = 1'b1; c.rf_we = 1'b1; end
            6'h0C:        begin c.aluop = 4'd7;  c.imm_op = 1'b1; c.rf_we = 1'b1; end
            6'h0D:        begin c.aluop = 4'd8;  c.imm_op = 1'b1; c.rf_we = 1'b1; end
            6'h0A:        begin c.aluop = 4'd11; c.imm_op = 1'b1; c.rf_we = 1'b1; end
            6'h23: begin
                c.aluop = 4'd5; c.imm_op = 1'b1; c.rf_we = 1'b1; c.mem_to_reg = 1'b1;
            end
            6'h0F:        begin c.imm_op = 1'b1; c.rf_we = 1'b1; c.lui = 1'b1; end
            6'h2B:        begin c.aluop = 4'd5; c.imm_op = 1'b1; c.mem_we = 1'b1; end
            6'h29: begin
                c.aluop = 4'd5; c.imm_op = 1'b1; c.mem_we = 1'b1; c.store_half = 1'b1;
            end
            6'h04:        begin c.aluop = 4'd6; c.branch = 1'b1; c.branch_eq = 1'b1; end
            6'h05:        begin c.aluop = 4'd6; c.branch = 1'b1; end
            6'h06:        begin c.branch = 1'b1; c.branch_leq = 1'b1; end
            6'h02:        c.jump = 1'b1;
            6'h03:        begin c.jump = 1'b1; c.jal = 1'b1; c.rf_we = 1'b1; end
            6'h10: begin
                if (mf == 5'h00) begin
                    mfc0    = 1'b1;
                    c.rf_we = 1'b1;
                end else if (mf == 5'h04) begin
                    mtc0 = 1'b1;
                end else if (mf == 5'h10 && funct == 6'h18) begin
                    exce_ret = 1'b1;
                end
            end
            default: c = '0;
        endcase
    end

    assign ctrl = c;

`ifdef ALU_MULDIV_EN
    // Sign-extending both operands to 64 bits makes the unsigned product equal the signed one.
    logic [63:0] prod;
    assign prod = {{32{alu_x[31]}}, alu_x} * {{32{alu_y[31]}}, alu_y};
`endif

    always_comb begin
        alu_r1 = '0;
        alu_r2 = '0;
        case (alu_op)
            4'd0:  alu_r1 = alu_y << alu_x[4:0];
            4'd1:  alu_r1 = $signed(alu_y) >>> alu_x[4:0];
            4'd2:  alu_r1 = alu_y >> alu_x[4:0];
`ifdef ALU_MULDIV_EN
            4'd3:  begin alu_r1 = prod[31:0]; alu_r2 = prod[63:32]; end
            4'd4: begin
                if (alu_y == '0) begin
                    alu_r1 = 32'hFFFF_FFFF;
                    alu_r2 = alu_x;
                end else begin
                    alu_r1 = alu_x / alu_y;
                    alu_r2 = alu_x % alu_y;
                end
            end
`endif
            4'd5:  alu_r1 = alu_x + alu_y;
            4'd6:  alu_r1 = alu_x - alu_y;
            4'd7:  alu_r1 = alu_x & alu_y;
            4'd8:  alu_r1 = alu_x | alu_y;
            4'd9:  alu_r1 = alu_x ^ alu_y;
            4'd10: alu_r1 = ~(alu_x | alu_y);
            4'd11: alu_r1 = {31'b0, $signed(alu_x) < $signed(alu_y)};
            4'd12: alu_r1 = {31'b0, alu_x < alu_y};
            default: ;
        endcase
    end

    assign alu_eq = (alu_x == alu_y);

    // Reset clears every word, so the array is built from flops rather than a RAM macro.
    logic [31:0] mem [1024];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
    end

    assign ram_dout = mem[ram_addr];

endmodule

// File: tb/tb_alu_controller_ram.sv
// Directed bench: expected values are queued as stimulus is applied and popped when outputs are sampled.
module tb_alu_controller_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  op, funct;
    logic [4:0]  mf;
    logic [18:0] ctrl;
    logic        exce_ret, mfc0, mtc0;
    logic [31:0] alu_x, alu_y, alu_r1, alu_r2;
    logic [3:0]  alu_op;
    logic        alu_eq;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din, ram_dout;
    logic        ram_we;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t sb[$];

    alu_controller_ram dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .mf(mf),
        .ctrl(ctrl), .exce_ret(exce_ret), .mfc0(mfc0), .mtc0(mtc0),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_eq(alu_eq),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Decoder: {ctrl, exce_ret, mfc0, mtc0}
    task automatic dec(input string tag, input logic [5:0] o, input logic [5:0] f,
                       input logic [4:0] m, input logic [21:0] exp_v);
        op = o; funct = f; mf = m;
        push(tag, {42'b0, exp_v});
        #1;
        pop_check({42'b0, ctrl, exce_ret, mfc0, mtc0});
    endtask

    // ALU: {r2, r1}; eq checked separately where it matters
    task automatic alu(input string tag, input logic [3:0] a, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] r2, input logic [31:0] r1);
        alu_op = a; alu_x = x; alu_y = y;
        push(tag, {r2, r1});
        #1;
        pop_check({alu_r2, alu_r1});
    endtask

    task automatic ram_chk(input string tag, input logic [31:0] v);
        push(tag, {32'b0, v});
        pop_check({32'b0, ram_dout});
    endtask

    initial begin
        rst_n = 1'b0; op = '0; funct = '0; mf = '0;
        alu_x = '0; alu_y = '0; alu_op = '0;
        ram_addr = 10'h3FF; ram_din = 32'hDEAD_BEEF; ram_we = 1'b1;

        // Writes are blocked while reset is held across an edge
        @(posedge clk); #1;
        ram_chk("ram_reset_blocks_write", 32'h0);

        // Decoder: fields {aluop, 15 flags} then exce_ret, mfc0, mtc0
        dec("dec_add_r",  6'h00, 6'h20, 5'h00, {4'd5,  15'h6000, 3'b000});
        dec("dec_sra_r",  6'h00, 6'h03, 5'h00, {4'd1,  15'h6004, 3'b000});
        dec("dec_jr",     6'h00, 6'h08, 5'h00, {4'd0,  15'h0020, 3'b000});
        dec("dec_xor_r_unlisted", 6'h00, 6'h26, 5'h00, 22'h0);
        dec("dec_lw",     6'h23, 6'h00, 5'h00, {4'd5,  15'h2300, 3'b000});
        dec("dec_sh",     6'h29, 6'h00, 5'h00, {4'd5,  15'h0501, 3'b000});
        dec("dec_beq",    6'h04, 6'h00, 5'h00, {4'd6,  15'h1080, 3'b000});
        dec("dec_slti",   6'h0A, 6'h00, 5'h00, {4'd11, 15'h2100, 3'b000});
        dec("dec_jal",    6'h03, 6'h00, 5'h00, {4'd0,  15'h2810, 3'b000});
        dec("dec_eret",   6'h10, 6'h18, 5'h10, {4'd0,  15'h0000, 3'b100});
        dec("dec_mfc0",   6'h10, 6'h00, 5'h00, {4'd0,  15'h2000, 3'b010});
        dec("dec_mtc0",   6'h10, 6'h00, 5'h04, {4'd0,  15'h0000, 3'b001});
        dec("dec_unlisted_op", 6'h3F, 6'h20, 5'h00, 22'h0);

        // ALU
        alu("alu_sub",  4'd6,  32'd5, 32'd7, 32'h0, 32'hFFFF_FFFE);
        push("alu_eq_ne", 64'd0);
        pop_check({63'b0, alu_eq});
        alu("alu_slt",  4'd11, 32'd5, 32'd7, 32'h0, 32'h1);
        alu("alu_slt_neg", 4'd11, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h1);
        alu("alu_sltu", 4'd12, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
        alu("alu_sra",  4'd1,  32'd4, 32'h8000_0000, 32'h0, 32'hF800_0000);
        alu("alu_srl",  4'd2,  32'd4, 32'h8000_0000, 32'h0, 32'h0800_0000);
        alu("alu_sll_mask", 4'd0, 32'h0000_0024, 32'h0000_0001, 32'h0, 32'h0000_0010);
        alu("alu_add_wrap", 4'd5, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h1);
        alu("alu_and",  4'd7,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0, 32'h00F0_1234);
        alu("alu_or",   4'd8,  32'hF000_0000, 32'h0000_000F, 32'h0, 32'hF000_000F);
        alu("alu_xor",  4'd9,  32'hFFFF_0000, 32'hF0F0_F0F0, 32'h0, 32'h0F0F_F0F0);
        alu("alu_nor",  4'd10, 32'hFFFF_0000, 32'h0000_00FF, 32'h0, 32'h0000_FF00);
        alu("alu_op13", 4'd13, 32'd9, 32'd9, 32'h0, 32'h0);
        push("alu_eq_eq", 64'd1);
        pop_check({63'b0, alu_eq});
`ifdef ALU_MULDIV_EN
        alu("alu_mul",  4'd3, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        alu("alu_divu", 4'd4, 32'd7, 32'd2, 32'd1, 32'd3);
        alu("alu_divu0", 4'd4, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
`else
        alu("alu_mul_off",  4'd3, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h0);
        alu("alu_divu_off", 4'd4, 32'd7, 32'd2, 32'h0, 32'h0);
`endif

        // RAM: release reset mid-cycle; the next rising edge performs the write
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        ram_chk("ram_old_before_edge", 32'h0);
        @(posedge clk); #1;
        ram_chk("ram_write_3ff", 32'hDEAD_BEEF);

        @(negedge clk);
        ram_addr = 10'h005; ram_din = 32'h1234_5678;
        @(posedge clk); #1;
        ram_chk("ram_write_005", 32'h1234_5678);
        @(negedge clk);
        ram_we = 1'b0; ram_din = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        ram_chk("ram_no_we_holds", 32'h1234_5678);
        ram_addr = 10'h3FF; #1;
        ram_chk("ram_readback_3ff", 32'hDEAD_BEEF);

        // Asynchronous clear mid-cycle
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        ram_chk("ram_async_clear_3ff", 32'h0);
        ram_addr = 10'h005; #1;
        ram_chk("ram_async_clear_005", 32'h0);
        rst_n = 1'b1;

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
